// File: rtl/fifo_rd_serializer.sv
// Pops DATA_WIDTH words from a sync_fifo master port and streams each one out
// as DATA_WIDTH/OUT_WIDTH narrow beats on a valid/ready interface.
module fifo_rd_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid_m,
    output logic                  o_ready_m,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_dataout,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_idle
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_params
        $error("fifo_rd_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      slice_idx;
    logic [OUT_WIDTH-1:0]  beat;
    logic                  at_last;

    assign at_last = (cnt == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid_m) begin
                        word  <= i_datain;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (i_ready) begin
                        if (!at_last) begin
                            cnt <= cnt + 1'b1;
                        end else if (i_valid_m) begin
                            // last beat accepted and next word ready: reload with no bubble
                            word <= i_datain;
                            cnt  <= '0;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign slice_idx = MSB_FIRST ? (LAST_CNT - cnt) : cnt;

    always_comb begin
        beat = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (32'(slice_idx) == i) begin
                beat = word[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    assign o_valid   = (state == SHIFT);
    assign o_idle    = (state == IDLE);
    assign o_dataout = o_valid ? beat : '0;
    assign o_first   = o_valid && (cnt == '0);
    assign o_last    = o_valid && at_last;
    // pop only when the current word is finished in this very cycle, so the head is never dropped
    assign o_ready_m = o_idle || (o_valid && at_last && i_ready);

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Scoreboard bench for fifo_rd_serializer: LSB-first and MSB-first instances fed
// by a behavioural FIFO, with expected beats queued at push time.
module tb_fifo_rd_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vm_a = 1'b0, rdy_m_a, rdy_a = 1'b0, ov_a, first_a, last_a, idle_a;
    logic [31:0] din_a = '0;
    logic [7:0]  dout_a;
    logic        vm_b = 1'b0, rdy_m_b, rdy_b = 1'b0, ov_b, first_b, last_b, idle_b;
    logic [31:0] din_b = '0;
    logic [7:0]  dout_b;

    fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_m(vm_a), .o_ready_m(rdy_m_a),
        .i_datain(din_a), .o_valid(ov_a), .i_ready(rdy_a), .o_dataout(dout_a),
        .o_first(first_a), .o_last(last_a), .o_idle(idle_a)
    );

    fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_m(vm_b), .o_ready_m(rdy_m_b),
        .i_datain(din_b), .o_valid(ov_b), .i_ready(rdy_b), .o_dataout(dout_b),
        .o_first(first_b), .o_last(last_b), .o_idle(idle_b)
    );

    typedef struct {
        logic [7:0] d;
        bit         f;
        bit         l;
    } beat_t;

    beat_t       exp_a[$];
    beat_t       exp_b[$];
    logic [31:0] fifo_a[$];
    logic [31:0] fifo_b[$];
    bit          pop_a = 1'b0, pop_b = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        fifo_a.push_back(w);
        for (int k = 0; k < 4; k++) exp_a.push_back('{w[k*8 +: 8], k == 0, k == 3});
        vm_a  = 1'b1;
        din_a = fifo_a[0];
    endtask

    task automatic push_b(input logic [31:0] w);
        fifo_b.push_back(w);
        for (int j = 0; j < 4; j++) exp_b.push_back('{w[(3-j)*8 +: 8], j == 0, j == 3});
        vm_b  = 1'b1;
        din_b = fifo_b[0];
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || fifo_a.size() != 0 || fifo_b.size() != 0)
               && n < budget) begin
            step();
            n++;
        end
        total++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d beats pending want 0", exp_a.size(), exp_b.size());
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    // monitors and FIFO pop sampling, away from the active edge
    always @(negedge clk) begin
        beat_t e;
        pop_a = rst_n && vm_a && rdy_m_a;
        pop_b = rst_n && vm_b && rdy_m_b;
        if (rst_n) begin
            if (!ov_a && dout_a != 8'h00) check("a_dout_zero_when_invalid", 32'(dout_a), 32'h0);
            if (ov_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    check("a_unexpected_beat", 32'(dout_a), 32'hFFFF_FFFF);
                end else begin
                    e = exp_a.pop_front();
                    check("a_data", 32'(dout_a), 32'(e.d));
                    check("a_first", 32'(first_a), 32'(e.f));
                    check("a_last", 32'(last_a), 32'(e.l));
                    check("a_ready_m_on_last", 32'(rdy_m_a), 32'(e.l));
                end
            end
            if (ov_b && rdy_b) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_beat", 32'(dout_b), 32'hFFFF_FFFF);
                end else begin
                    e = exp_b.pop_front();
                    check("b_data", 32'(dout_b), 32'(e.d));
                    check("b_first", 32'(first_b), 32'(e.f));
                    check("b_last", 32'(last_b), 32'(e.l));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_a && fifo_a.size() != 0) void'(fifo_a.pop_front());
        if (pop_b && fifo_b.size() != 0) void'(fifo_b.pop_front());
        pop_a = 1'b0;
        pop_b = 1'b0;
        vm_a  = (fifo_a.size() != 0);
        din_a = vm_a ? fifo_a[0] : '0;
        vm_b  = (fifo_b.size() != 0);
        din_b = vm_b ? fifo_b[0] : '0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gaps, pulses, mism;

        // reset held with a word already waiting at the FIFO head
        rdy_a = 1'b1;
        push_a(32'hCAFE_F00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_valid", 32'(ov_a), 32'h0);
            check("rst_dout", 32'(dout_a), 32'h0);
            check("rst_first_last", 32'({first_a, last_a}), 32'h0);
            check("rst_idle", 32'(idle_a), 32'h1);
            check("rst_ready_m", 32'(rdy_m_a), 32'h1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain(40);

        // single word, LSB first
        push_a(32'hA1B2_C3D4);
        drain(40);
        check("idle_after_word", 32'(idle_a), 32'h1);

        // eight back-to-back words, no bubbles
        for (int w = 1; w <= 8; w++) push_a(32'(w));
        step();
        gaps = 0;
        pulses = 0;
        mism = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (!ov_a) gaps++;
            if (rdy_m_a) pulses++;
            if (rdy_m_a != last_a) mism++;
            @(posedge clk);
            #2;
        end
        check("burst_gaps", 32'(gaps), 32'd0);
        check("burst_ready_m_pulses", 32'(pulses), 32'd8);
        check("burst_ready_m_vs_last", 32'(mism), 32'd0);
        check("burst_fifo_empty", 32'(fifo_a.size()), 32'd0);
        check("burst_valid_after", 32'(ov_a), 32'h0);
        drain(20);

        // backpressure on C3 with a second word waiting in the FIFO
        rdy_a = 1'b0;
        push_a(32'hA1B2_C3D4);
        push_a(32'h0000_0005);
        step();
        rdy_a = 1'b1;
        step();
        rdy_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(ov_a), 32'h1);
            check("stall_dout", 32'(dout_a), 32'hC3);
            check("stall_ready_m", 32'(rdy_m_a), 32'h0);
            @(posedge clk);
            #2;
        end
        check("stall_no_pop", 32'(fifo_a.size()), 32'd1);
        rdy_a = 1'b1;
        drain(40);

        // MSB-first instance
        rdy_b = 1'b1;
        push_b(32'hA1B2_C3D4);
        drain(40);

        // asynchronous reset mid-word: the remaining 22/11 beats are discarded
        push_a(32'h1122_3344);
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ov_a), 32'h0);
        check("async_rst_dout", 32'(dout_a), 32'h0);
        check("async_rst_idle", 32'(idle_a), 32'h1);
        check("async_rst_beats_left", 32'(exp_a.size()), 32'd2);
        exp_a.delete();
        step();
        step();
        rst_n = 1'b1;
        push_a(32'h5566_7788);
        drain(40);
        check("final_idle", 32'(idle_a), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_serializer.md
# fifo_rd_serializer

Read-side companion to `sync_fifo`. It connects to the FIFO master port (`o_valid_m`/`i_ready_m`/`o_dataout`) and pops one DATA_WIDTH word at a time. Each word is split into DATA_WIDTH/OUT_WIDTH narrow beats and sent on a valid/ready stream toward a narrow consumer. Back-to-back words flow with zero bubble cycles.

## Interface
- DATA_WIDTH, 32, FIFO word width; must equal the connected `sync_fifo` DATA_WIDTH
- OUT_WIDTH, 8, output beat width; DATA_WIDTH % OUT_WIDTH == 0 is required
- MSB_FIRST, 0, 0 sends the least-significant slice first; 1 sends the most-significant slice first
- RATIO (localparam) = DATA_WIDTH/OUT_WIDTH; must be ≥2. Beat counter width is $clog2(RATIO). Elaboration fails if either rule is violated.

- i_clk  in  1  single clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid_m  in  1  FIFO has a word (from `o_valid_m`)
- o_ready_m  out  1  pop request (to `i_ready_m`); a word is consumed on a rising edge where i_valid_m & o_ready_m
- i_datain  in  DATA_WIDTH  FIFO head word (from `o_dataout`)
- o_valid  out  1  beat valid
- i_ready  in  1  downstream accepts beat
- o_dataout  out  OUT_WIDTH  current beat
- o_first  out  1  current beat is slice 0 of a word
- o_last  out  1  current beat is the final slice of a word
- o_idle  out  1  no word held

## Operation
- State: IDLE or SHIFT. Storage: buf[DATA_WIDTH-1:0] and cnt.
- IDLE:
  - o_valid=0, o_ready_m=1.
  - If i_valid_m: buf<=i_datain, cnt<=0, go to SHIFT.
- SHIFT:
  - o_valid=1.
  - Slice index k = cnt when MSB_FIRST=0, else RATIO-1-cnt.
  - o_dataout = buf[k*OUT_WIDTH +: OUT_WIDTH].
- Beat handshake (o_valid & i_ready), cnt < RATIO-1: cnt<=cnt+1.
- Beat handshake, cnt == RATIO-1:
  - If i_valid_m: buf<=i_datain, cnt<=0, stay in SHIFT (back-to-back).
  - Else go to IDLE.
- o_ready_m = (IDLE) | (SHIFT & cnt==RATIO-1 & i_ready). This is combinational from i_ready; no combinational path from i_valid_m.
- o_first = o_valid & cnt==0. o_last = o_valid & cnt==RATIO-1. o_idle = (state==IDLE).
- o_dataout = 0 whenever o_valid=0.
- Stream rules:
  - Once o_valid is asserted, o_valid and o_dataout hold until the handshake.
  - o_valid never depends on i_ready.
  - The block never pops a word it cannot hold.

## Timing
- Reset (async assert, sync release):
  - State IDLE, cnt 0, buf 0.
  - Outputs: o_valid 0, o_dataout 0, o_first 0, o_last 0, o_idle 1, o_ready_m 1. This is harmless because the FIFO's o_valid_m is 0 in reset.
- Latency: a word popped at edge N appears as its first beat in the cycle after edge N.
- Throughput: with i_ready held at 1, one word every RATIO cycles and 100% beat utilization.
- o_ready_m pulses for exactly one cycle per word while streaming: during the last beat's handshake cycle.
- FIFO empty during a last beat: go to IDLE, one idle cycle minimum before the next word's first beat.
- Backpressure on the last beat: o_ready_m stays 0, so the FIFO head is not popped.
- Reset mid-word: remaining beats are discarded, with no flush. After release, the next word starts at slice 0.
- A simultaneous last-beat handshake and FIFO valid always reloads; the head word is never skipped or duplicated.

## Test plan
1. Reset with i_valid_m=1, held low for 3 cycles -> all outputs at reset values, no beats. The first word after release has o_first=1.
2. One word 0xA1B2C3D4, i_ready=1, MSB_FIRST=0 -> beats D4,C3,B2,A1 on 4 consecutive cycles. o_first on D4, o_last on A1. o_idle returns to 1 afterwards.
3. With `sync_fifo` (depth 8), fill words 0x00000001..0x00000008, then i_ready=1 -> 32 contiguous beats, no o_valid gaps. o_ready_m pulses 8 times, each coincident with o_last. FIFO o_empty is 1 at the end.
4. Backpressure: word 0xA1B2C3D4, drop i_ready for 3 cycles at beat C3 -> o_dataout holds C3 and o_valid stays 1. No pop occurs, even with the FIFO non-empty. The sequence then completes B2,A1.
5. MSB_FIRST=1, word 0xA1B2C3D4 -> beats A1,B2,C3,D4.
6. Assert i_rst_n=0 asynchronously after 2 beats of 0x11223344 -> o_valid drops immediately. After release, the next FIFO word streams from slice 0, and no 22/11 beats appear.
